video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the HDMI/TMDS output path, running in the pixel clock domain.
- Drives hsync/vsync/de into the TMDS encoders and provides pixel coordinates to the video-RAM datapath.
- Adds a programmable look-ahead timing copy so a RAM fetch pipeline can run ahead of the display.
- Adds a pixel-enable input, so a single block serves 640x480, 800x600 and 1024x768 through parameters only.

---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/video_timing_axis.sv | 47 ++++
 rtl/video_timing_gen.sv | 113 +++++++++++
 tb/tb_video_timing_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing presets and helpers for the raster timing generator.
package video_timing_pkg;

  // One axis of a video mode: visible span, porches, sync width and sync level.
  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_timing_t;

  // VGA 640x480@60 (25.175 MHz pixel clock)
  localparam axis_timing_t VGA_H  = '{active: 640,  fp: 16, sync: 96,  bp: 48,  pol: 1'b0};
  localparam axis_timing_t VGA_V  = '{active: 480,  fp: 10, sync: 2,   bp: 33,  pol: 1'b0};

  // SVGA 800x600@60 (40 MHz pixel clock)
  localparam axis_timing_t SVGA_H = '{active: 800,  fp: 40, sync: 128, bp: 88,  pol: 1'b1};
  localparam axis_timing_t SVGA_V = '{active: 600,  fp: 1,  sync: 4,   bp: 23,  pol: 1'b1};

  // XGA 1024x768@60 (65 MHz pixel clock)
  localparam axis_timing_t XGA_H  = '{active: 1024, fp: 24, sync: 136, bp: 160, pol: 1'b0};
  localparam axis_timing_t XGA_V  = '{active: 768,  fp: 3,  sync: 6,   bp: 29,  pol: 1'b0};

  // Total count of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Total count of a preset axis.
  function automatic int preset_total(input axis_timing_t t);
    return axis_total(t.active, t.fp, t.sync, t.bp);
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping counter plus region decode (active, sync, last).
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter int INIT   = 0,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         step,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         active,
  output logic         in_sync,
  output logic         wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Region boundaries are compared one bit wider than the counter so that a
  // boundary equal to 2**W (zero back porch on a full-width counter) still works.
  localparam logic [W:0] ACT_END    = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_BEGIN = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0] LAST       = (W+1)'(TOTAL - 1);

  logic [W:0] count_ext;

  assign count_ext = {1'b0, count};
  assign active    = (count_ext < ACT_END);
  assign in_sync   = (count_ext >= SYNC_BEGIN) && (count_ext < SYNC_END);
  assign wrap      = (count_ext == LAST);

  // Advance when the raster moves and this axis is told to count; wrap after the last position.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= W'(INIT);
    end else if (step && inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered sync/de/position outputs plus a
// look-ahead copy running LEAD pixels ahead for the video-RAM fetch pipeline.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   LEAD     = 2,
  parameter int   X_W      = 11,
  parameter int   Y_W      = 10
) (
  input  logic           clk_pixel,
  input  logic           resetn,
  input  logic           enable,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_start,
  output logic           de_lead,
  output logic [X_W-1:0] lead_x,
  output logic [Y_W-1:0] lead_y
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((2 ** X_W) < H_TOTAL) begin : g_bad_x_w
    $error("video_timing_gen: X_W too narrow for H_TOTAL");
  end
  if ((2 ** Y_W) < V_TOTAL) begin : g_bad_y_w
    $error("video_timing_gen: Y_W too narrow for V_TOTAL");
  end
  if ((LEAD < 0) || (LEAD >= H_TOTAL)) begin : g_bad_lead
    $error("video_timing_gen: LEAD must be in 0..H_TOTAL-1");
  end

  logic [X_W-1:0] h_count, lh_count;
  logic [Y_W-1:0] v_count, lv_count;
  logic           h_active, v_active, lh_active, lv_active;
  logic           h_sync, v_sync, lh_sync, lv_sync;
  logic           h_wrap, v_wrap, lh_wrap, lv_wrap;
  logic           unused_axis_flags;

  // The lead copy has no sync outputs and neither vertical wrap is needed.
  assign unused_axis_flags = lh_sync ^ lv_sync ^ v_wrap ^ lv_wrap;

  video_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .INIT(0), .W(X_W)
  ) u_main_h (
    .clk(clk_pixel), .resetn(resetn), .step(enable), .inc(1'b1),
    .count(h_count), .active(h_active), .in_sync(h_sync), .wrap(h_wrap)
  );

  video_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .INIT(0), .W(Y_W)
  ) u_main_v (
    .clk(clk_pixel), .resetn(resetn), .step(enable), .inc(h_wrap),
    .count(v_count), .active(v_active), .in_sync(v_sync), .wrap(v_wrap)
  );

  video_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .INIT(LEAD % H_TOTAL), .W(X_W)
  ) u_lead_h (
    .clk(clk_pixel), .resetn(resetn), .step(enable), .inc(1'b1),
    .count(lh_count), .active(lh_active), .in_sync(lh_sync), .wrap(lh_wrap)
  );

  video_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .INIT(0), .W(Y_W)
  ) u_lead_v (
    .clk(clk_pixel), .resetn(resetn), .step(enable), .inc(lh_wrap),
    .count(lv_count), .active(lv_active), .in_sync(lv_sync), .wrap(lv_wrap)
  );

  // Register every output from the pre-increment counter values; hold everything while stalled.
  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      de_lead     <= 1'b0;
      lead_x      <= '0;
      lead_y      <= '0;
    end else if (enable) begin
      hsync       <= h_sync ? HS_POL : ~HS_POL;
      vsync       <= v_sync ? VS_POL : ~VS_POL;
      de          <= h_active && v_active;
      x           <= h_count;
      y           <= v_count;
      frame_start <= (h_count == '0) && (v_count == '0);
      line_start  <= (h_count == '0);
      de_lead     <= lh_active && lv_active;
      lead_x      <= lh_count;
      lead_y      <= lv_count;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster so several frames fit.
// The reference model tracks a single linear pixel index per frame and derives
// every output from it with division and modulo.
module tb_video_timing_gen;

  localparam int   HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
  localparam logic HSP = 1'b1, VSP = 1'b1;
  localparam int   LEAD = 3;
  localparam int   XW = 4, YW = 3;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_start;
    logic          line_start;
    logic          de_lead;
    logic [XW-1:0] lead_x;
    logic [YW-1:0] lead_y;
  } out_t;

  logic          clk_pixel = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          hsync, vsync, de, frame_start, line_start, de_lead;
  logic [XW-1:0] x, lead_x;
  logic [YW-1:0] y, lead_y;

  out_t exp_q[$];
  out_t model_out;
  int   model_pos = 0;
  int   check_count = 0;
  int   pass_count = 0;
  int   cycle = 0;

  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) cycle <= cycle + 1;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .LEAD(LEAD), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk_pixel(clk_pixel), .resetn(resetn), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .de_lead(de_lead), .lead_x(lead_x), .lead_y(lead_y)
  );

  function automatic out_t reset_out();
    out_t o;
    o             = '0;
    o.hsync       = ~HSP;
    o.vsync       = ~VSP;
    return o;
  endfunction

  // Outputs for the raster position with linear index p within a frame.
  function automatic out_t decode(input int p);
    out_t o;
    int h, v, lp, lh, lv;
    h  = p % HT;
    v  = p / HT;
    lp = (p + LEAD) % FT;
    lh = lp % HT;
    lv = lp / HT;
    o.hsync       = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
    o.vsync       = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
    o.de          = (h < HA) && (v < VA);
    o.x           = XW'(h);
    o.y           = YW'(v);
    o.frame_start = (p == 0);
    o.line_start  = (h == 0);
    o.de_lead     = (lh < HA) && (lv < VA);
    o.lead_x      = XW'(lh);
    o.lead_y      = YW'(lv);
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs the following edge must produce.
  task automatic applyStimulus(input logic rst_n, input logic en);
    @(negedge clk_pixel);
    resetn = rst_n;
    enable = en;
    if (!rst_n) begin
      model_pos = 0;
      model_out = reset_out();
    end else if (en) begin
      model_out = decode(model_pos);
      model_pos = (model_pos + 1) % FT;
    end
    exp_q.push_back(model_out);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    check_count++;
    if (actual === required) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cycle, actual, required);
    end
  endtask

  // Monitor: after every edge, pop the pending expectation and compare each output.
  initial begin
    out_t e;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hsync",       32'(hsync),       32'(e.hsync));
        checkOutput("vsync",       32'(vsync),       32'(e.vsync));
        checkOutput("de",          32'(de),          32'(e.de));
        checkOutput("x",           32'(x),           32'(e.x));
        checkOutput("y",           32'(y),           32'(e.y));
        checkOutput("frame_start", 32'(frame_start), 32'(e.frame_start));
        checkOutput("line_start",  32'(line_start),  32'(e.line_start));
        checkOutput("de_lead",     32'(de_lead),     32'(e.de_lead));
        checkOutput("lead_x",      32'(lead_x),      32'(e.lead_x));
        checkOutput("lead_y",      32'(lead_y),      32'(e.lead_y));
      end
    end
  end

  initial begin
    int guard;
    model_out = reset_out();

    $display("[TB] reset held for 5 cycles with enable high");
    repeat (5) applyStimulus(1'b0, 1'b1);

    $display("[TB] free run for two frames");
    repeat (2 * FT + 1) applyStimulus(1'b1, 1'b1);

    $display("[TB] stall 10 cycles mid-line");
    guard = 0;
    while (model_pos != 6 && guard < 2 * FT) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    repeat (10) applyStimulus(1'b1, 1'b0);
    repeat (HT) applyStimulus(1'b1, 1'b1);

    $display("[TB] stall 10 cycles while frame_start is high");
    guard = 0;
    while (!model_out.frame_start && guard < 2 * FT) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    repeat (10) applyStimulus(1'b1, 1'b0);
    repeat (2 * HT) applyStimulus(1'b1, 1'b1);

    $display("[TB] reset asserted with the counter at (5,2)");
    guard = 0;
    while (model_pos != 2 * HT + 5 && guard < 2 * FT) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    applyStimulus(1'b0, 1'b1);
    repeat (3 * FT) applyStimulus(1'b1, 1'b1);

    $display("[TB] random enable and occasional reset");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0));
    end
    repeat (FT) applyStimulus(1'b1, 1'b1);

    repeat (3) @(negedge clk_pixel);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
